// File: rtl/env_gen_tdm.sv
// env_gen_tdm: ADSR envelope generator shared by NUM_UNITS channels.
// One add/subtract datapath visits the channels round-robin; channel i is
// updated only on the clock edge where slot == i.
//
// Ports:
//   aud_clk     clock
//   aud_rst     asynchronous active-low reset
//   attack_in   packed per-channel attack rate (larger = slower)
//   decay_in    packed per-channel decay rate
//   sustain_in  packed per-channel sustain level (sampled live)
//   release_in  packed per-channel release rate
//   trigger     per-channel gate; a rising edge (re)starts the attack
//   in_use      channel state is not IDLE
//   env_out     packed envelope, integer part of each accumulator
//
// Build option: define EG_EXP_RELEASE_EN for exponential release
// (step = (acc >> (1 + release[msb:msb-2])) + 1). Default is linear.
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | channel silent, acc held at 0
// ST_ATTACK  | acc rising by the attack step toward FULL
// ST_DECAY   | acc falling by the decay step toward SUS
// ST_SUSTAIN | acc follows the sustain input every slot
// ST_RELEASE | gate low, acc falling toward 0
module env_gen_tdm #(
  parameter int EG_WIDTH  = 8,
  parameter int NUM_UNITS = 4,
  parameter int FRAC_W    = 8
) (
  input  logic                          aud_clk,
  input  logic                          aud_rst,
  input  logic [EG_WIDTH*NUM_UNITS-1:0] attack_in,
  input  logic [EG_WIDTH*NUM_UNITS-1:0] decay_in,
  input  logic [EG_WIDTH*NUM_UNITS-1:0] sustain_in,
  input  logic [EG_WIDTH*NUM_UNITS-1:0] release_in,
  input  logic [NUM_UNITS-1:0]          trigger,
  output logic [NUM_UNITS-1:0]          in_use,
  output logic [EG_WIDTH*NUM_UNITS-1:0] env_out
);

  localparam int ACC_W  = EG_WIDTH + FRAC_W;
  localparam int AW     = ACC_W + 1;  // one guard bit so sums never wrap
  localparam int SLOT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [AW-1:0] FULL = {1'b0, {EG_WIDTH{1'b1}}, {FRAC_W{1'b0}}};
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_UNITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } state_e;

  logic [SLOT_W-1:0]    slot_q;
  logic [NUM_UNITS-1:0] trig_q;
  logic [NUM_UNITS-1:0] pend_q, pend_d;
  logic [NUM_UNITS-1:0] slot_oh;
  state_e               state_q [NUM_UNITS];
  logic [AW-1:0]        acc_q   [NUM_UNITS];

  logic [EG_WIDTH-1:0] att_sel, dec_sel, sus_sel, rel_sel;
  state_e              cur_state, state_d;
  logic [AW-1:0]       cur_acc, acc_d;
  logic [AW-1:0]       step_a, step_d, step_r, sus_lvl, att_sum, dec_lim;
  logic                cur_pend, cur_gate, att_sat;

  // step = 2^EG_WIDTH - param, zero-extended into accumulator units
  function automatic logic [AW-1:0] lin_step(input logic [EG_WIDTH-1:0] p);
    logic [EG_WIDTH:0] s;
    s = {1'b1, {EG_WIDTH{1'b0}}} - {1'b0, p};
    return {{FRAC_W{1'b0}}, s};
  endfunction

  // Per-slot operand selection
  always_comb begin
    att_sel   = attack_in [int'(slot_q)*EG_WIDTH +: EG_WIDTH];
    dec_sel   = decay_in  [int'(slot_q)*EG_WIDTH +: EG_WIDTH];
    sus_sel   = sustain_in[int'(slot_q)*EG_WIDTH +: EG_WIDTH];
    rel_sel   = release_in[int'(slot_q)*EG_WIDTH +: EG_WIDTH];
    cur_state = state_q[slot_q];
    cur_acc   = acc_q[slot_q];
    cur_pend  = pend_q[slot_q];
    cur_gate  = trig_q[slot_q];
  end

  assign step_a  = lin_step(att_sel);
  assign step_d  = lin_step(dec_sel);
  assign sus_lvl = {1'b0, sus_sel, {FRAC_W{1'b0}}};
  assign att_sum = cur_acc + step_a;
  assign att_sat = (att_sum >= FULL);
  assign dec_lim = sus_lvl + step_d;

`ifdef EG_EXP_RELEASE_EN
  logic [3:0] rel_shift;
  assign rel_shift = {1'b0, rel_sel[EG_WIDTH-1 -: 3]} + 4'd1;
  assign step_r    = (cur_acc >> rel_shift) + AW'(1);
`else
  assign step_r = lin_step(rel_sel);
`endif

  // Next state/accumulator for the channel owning this slot
  always_comb begin
    state_d = cur_state;
    acc_d   = cur_acc;
    if (cur_pend) begin
      // retrigger continues from the present level
      acc_d   = att_sat ? FULL : att_sum;
      state_d = att_sat ? ST_DECAY : ST_ATTACK;
    end else begin
      case (cur_state)
        ST_ATTACK: begin
          if (!cur_gate) begin
            state_d = ST_RELEASE;
          end else begin
            acc_d   = att_sat ? FULL : att_sum;
            state_d = att_sat ? ST_DECAY : ST_ATTACK;
          end
        end
        ST_DECAY: begin
          if (!cur_gate) begin
            state_d = ST_RELEASE;
          end else if (cur_acc <= dec_lim) begin
            // also covers sustain above the current level
            acc_d   = sus_lvl;
            state_d = ST_SUSTAIN;
          end else begin
            acc_d = cur_acc - step_d;
          end
        end
        ST_SUSTAIN: begin
          if (!cur_gate) begin
            state_d = ST_RELEASE;
          end else begin
            acc_d = sus_lvl;
          end
        end
        ST_RELEASE: begin
          if (cur_acc <= step_r) begin
            acc_d   = '0;
            state_d = ST_IDLE;
          end else begin
            acc_d = cur_acc - step_r;
          end
        end
        default: begin
          acc_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // A rise seen on the slot's own edge must survive that slot's clear
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      slot_oh[i] = (slot_q == SLOT_W'(i));
    end
    pend_d = (trigger & ~trig_q) | (pend_q & ~slot_oh);
  end

  always_ff @(posedge aud_clk or negedge aud_rst) begin
    if (!aud_rst) begin
      slot_q <= '0;
      trig_q <= '0;
      pend_q <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        state_q[i] <= ST_IDLE;
        acc_q[i]   <= '0;
      end
    end else begin
      slot_q          <= (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
      trig_q          <= trigger;
      pend_q          <= pend_d;
      state_q[slot_q] <= state_d;
      acc_q[slot_q]   <= acc_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      env_out[i*EG_WIDTH +: EG_WIDTH] = acc_q[i][ACC_W-1:FRAC_W];
      in_use[i] = (state_q[i] != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_env_gen_tdm.sv
module tb_env_gen_tdm;
  localparam int EGW = 8;
  localparam int NU  = 4;
  localparam int FW  = 8;

  logic              aud_clk = 1'b0;
  logic              aud_rst;
  logic [EGW*NU-1:0] attack_in, decay_in, sustain_in, release_in, env_out;
  logic [NU-1:0]     trigger, in_use;

  env_gen_tdm #(.EG_WIDTH(EGW), .NUM_UNITS(NU), .FRAC_W(FW)) dut (
    .aud_clk    (aud_clk),
    .aud_rst    (aud_rst),
    .attack_in  (attack_in),
    .decay_in   (decay_in),
    .sustain_in (sustain_in),
    .release_in (release_in),
    .trigger    (trigger),
    .in_use     (in_use),
    .env_out    (env_out)
  );

  always #5 aud_clk = ~aud_clk;

  typedef struct packed {
    logic [7:0] env;
    logic       use_;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   nxt_slot = 0;
  int   acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] env_of(input int ch);
    return env_out[ch*EGW +: EGW];
  endfunction

  function automatic int rel_step(input int a, input logic [7:0] rel);
`ifdef EG_EXP_RELEASE_EN
    return (a >> (1 + int'(rel[7:5]))) + 1;
`else
    return 256 - int'(rel);
`endif
  endfunction

  task automatic push(input int env, input bit u);
    exp_t e;
    e.env  = 8'(env);
    e.use_ = u;
    sb_q.push_back(e);
  endtask

  // one clock; reports which channel slot that edge processed
  task automatic tick(output int s);
    @(posedge aud_clk);
    s = nxt_slot;
    nxt_slot = (nxt_slot + 1) % NU;
    #1;
  endtask

  task automatic step_ch(input int ch);
    int s;
    int guard;
    guard = 0;
    do begin
      tick(s);
      guard++;
    end while (s != ch && guard < NU + 1);
  endtask

  task automatic sb_pop(input int ch, input string tag);
    exp_t e;
    step_ch(ch);
    e = sb_q.pop_front();
    chk({tag, " env"}, 32'(env_of(ch)), 32'(e.env));
    chk({tag, " in_use"}, 32'(in_use[ch]), 32'(e.use_));
  endtask

  task automatic drain(input int ch, input string tag);
    while (sb_q.size() > 0) sb_pop(ch, tag);
  endtask

  // push the model's release sequence from acc down to IDLE
  task automatic push_release_to_idle(input logic [7:0] rel);
    int st;
    while (acc > 0) begin
      st  = rel_step(acc, rel);
      acc = (acc <= st) ? 0 : acc - st;
      push(acc >> 8, acc != 0);
    end
  endtask

  task automatic do_reset();
    aud_rst = 1'b0;
    #150;
    chk("reset env_out", env_out, 32'h0);
    chk("reset in_use", 32'(in_use), 32'h0);
    @(negedge aud_clk);
    aud_rst  = 1'b1;
    nxt_slot = 0;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog time limit expired");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    int st;
    aud_rst    = 1'b1;
    trigger    = '0;
    attack_in  = '0;
    decay_in   = '0;
    sustain_in = {NU{8'h40}};
    release_in = '0;
    #1;
    do_reset();
    step_ch(3);
    chk("idle after reset", env_out, 32'h0);

    // attack to full, decay to 0x40, hold
    step_ch(0);
    trigger[0] = 1'b1;
    for (int v = 1; v <= 255; v++) push(v, 1'b1);
    for (int v = 254; v >= 64; v--) push(v, 1'b1);
    for (int k = 0; k < 4; k++) push(8'h40, 1'b1);
    drain(0, "attack/decay");
    chk("others idle", 32'(env_out[EGW*NU-1:EGW]), 32'h0);

    // release from sustain: first slot applies no step
    trigger[0] = 1'b0;
    push(8'h40, 1'b1);
    acc = 32'h4000;
    push_release_to_idle(8'h00);
    drain(0, "release");

    // rise and fall inside one scan: one attack slot, then release
    trigger[0] = 1'b1;
    step_ch(1);
    step_ch(2);
    trigger[0] = 1'b0;
    push(8'h01, 1'b1);
    push(8'h01, 1'b1);
    acc = 32'h0100;
    push_release_to_idle(8'h00);
    drain(0, "short pulse");

    // sustain at full scale, then live sustain change
    sustain_in[7:0] = 8'hFF;
    trigger[0] = 1'b1;
    for (int v = 1; v <= 255; v++) push(v, 1'b1);
    for (int k = 0; k < 3; k++) push(8'hFF, 1'b1);
    drain(0, "sustain full");
    sustain_in[7:0] = 8'h80;
    push(8'h80, 1'b1);
    push(8'h80, 1'b1);
    drain(0, "sustain live");

    // release down to 0x20, then retrigger from there
    trigger[0] = 1'b0;
    push(8'h80, 1'b1);
    drain(0, "release2 entry");
    acc = 32'h8000;
    while ((acc >> 8) > 32'h20) begin
      st  = rel_step(acc, 8'h00);
      acc = (acc <= st) ? 0 : acc - st;
      push(acc >> 8, acc != 0);
      sb_pop(0, "release2");
    end
    trigger[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      acc = acc + 256;
      push(acc >> 8, 1'b1);
    end
    drain(0, "retrigger");

    // asynchronous reset in the middle of an attack
    #2;
    aud_rst = 1'b0;
    #1;
    chk("async reset env_out", env_out, 32'h0);
    chk("async reset in_use", 32'(in_use), 32'h0);
    trigger = '0;
    do_reset();

    // slow attack on ch1 next to a fast ch2
    attack_in[15:8]   = 8'hFF;
    attack_in[23:16]  = 8'h00;
    sustain_in[15:8]  = 8'hFF;
    sustain_in[23:16] = 8'hFF;
    step_ch(0);
    trigger = 4'b0110;
    for (int k = 0; k < 255; k++) step_ch(1);
    push(8'h00, 1'b1);
    push(8'h01, 1'b1);
    drain(1, "slow attack");
    chk("fast ch2 env", 32'(env_of(2)), 32'hFF);
    chk("fast ch2 in_use", 32'(in_use[2]), 32'h1);
    chk("ch0 untouched", 32'(env_of(0)), 32'h0);
    chk("ch3 untouched", 32'(env_of(3)), 32'h0);
    chk("ch0/ch3 in_use", 32'({in_use[3], in_use[0]}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/env_gen_tdm.md
# env_gen_tdm

- Time-multiplexed, parametrised ADSR envelope generator for the synthesizer voice path.
- Successor to the per-unit envelope generator:
  - a single shared add/subtract datapath scans `NUM_UNITS` channels round-robin;
  - per-channel accumulators carry fractional resolution;
  - retrigger from the current level (no jump to zero);
  - sustain tracks its input live.
- Sits between the voice-allocation registers and the amplitude multipliers.

## Interface
- `EG_WIDTH`, 8: width of each ADSR parameter and of each envelope output.
- `NUM_UNITS`, 4: channel count, ≥2.
- `FRAC_W`, 8: fractional accumulator bits. `ACC_W = EG_WIDTH+FRAC_W`.
- `aud_clk`  in  1: clock.
- `aud_rst`  in  1: reset. One clock, asynchronous assert, active-low.
- `attack_in`  in  `EG_WIDTH*NUM_UNITS`: packed per-channel attack; channel i at `[EG_WIDTH*(i+1)-1:EG_WIDTH*i]`. Larger value means slower.
- `decay_in`  in  `EG_WIDTH*NUM_UNITS`: packed decay rate.
- `sustain_in`  in  `EG_WIDTH*NUM_UNITS`: packed sustain level.
- `release_in`  in  `EG_WIDTH*NUM_UNITS`: packed release rate.
- `trigger`  in  `NUM_UNITS`: per-channel gate. Level is held for note on.
- `in_use`  out  `NUM_UNITS`: channel state is not IDLE.
- `env_out`  out  `EG_WIDTH*NUM_UNITS`: packed envelope, equal to the integer part of the accumulator.

## Operation
- **Slot counter `slot`:**
  - counts 0..`NUM_UNITS-1` and wraps;
  - channel i is updated only on the edge where `slot==i`.
- **Step size:** `step = 2^EG_WIDTH − param`, giving the range 1..2^EG_WIDTH and `EG_WIDTH+1` bits. With `FRAC_W=8`, param 0 gives 1 output LSB per update.
- **`FULL`:** `(2^EG_WIDTH−1)<<FRAC_W`.
- **`SUS`:** `sustain<<FRAC_W`.
- **Edge capture:** `trigger` is registered every clock. A 0→1 edge sets `pend[i]`, which is cleared at channel i's slot.
- **States:** IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- **Transitions (evaluated at the channel's slot):**
  - `pend` set, from any state: → ATTACK from the current acc, and apply one attack step this slot.
  - ATTACK:
    - if `acc+step_a ≥ FULL`: acc=`FULL`, → DECAY;
    - else `acc += step_a`.
  - DECAY:
    - if `acc ≤ SUS+step_d`: acc=`SUS`, → SUSTAIN;
    - else `acc −= step_d`.
  - SUSTAIN: acc=`SUS` every slot, so sustain changes apply live.
  - Gate low in ATTACK/DECAY/SUSTAIN: → RELEASE. No step is applied this slot.
  - RELEASE:
    - if `acc ≤ step_r`: acc=0, → IDLE;
    - else `acc −= step_r`.
  - IDLE: acc=0.
- **Priority:** `pend` > gate low. A rise and a fall within one scan period give one ATTACK slot, then RELEASE at the next slot.
- **Arithmetic:** all `ACC_W+1` bits wide. No wrap is ever permitted; saturation is explicit as above.
- **Sustain above the attack peak:** if sustain is greater than the level on entering DECAY (sustain=all ones), DECAY exits to SUSTAIN on its first slot.

## Timing
- **Reset** (`aud_rst` low, asynchronous), for all channels:
  - `slot`=0, state=IDLE, acc=0, `pend`=0;
  - `env_out`=0, `in_use`=0.
- **Reset mid-operation:** forces the same values immediately. On release, the first update processes channel 0.
- **Update rate:** each channel is updated once every `NUM_UNITS` clocks.
- **Output update:** `env_out[i]` and `in_use[i]` are registered and change on the same edge as channel i's state update.
- **Trigger latency:** `trigger` rise to first `env_out` change is 2..`NUM_UNITS+1` clocks.
- **Inputs:** parameter inputs are sampled only at the channel's slot. They may change at any time.

## Configuration
- **`EG_EXP_RELEASE_EN` defined:** RELEASE becomes exponential.
  - `shift = 1 + release[EG_WIDTH-1:EG_WIDTH-3]`, range 1..8.
  - `step_r = (acc>>shift) + 1`.
  - Termination rule is unchanged: `acc ≤ step_r` → 0, IDLE.
- **Undefined:** linear release as above.
- Attack and decay are linear in both builds.

## Test plan
Defaults apply unless stated.
- **Reset:** hold `aud_rst`=0 for 150 ns, then deassert → all `env_out`=0, `in_use`=0. Asserting reset mid-attack returns to 0 asynchronously.
- **Attack/decay:** attack=0, decay=0, sustain=0x40, ch0 gate high →
  - `env_out[0]` +1 per 4 clocks, reaching 0xFF after 255 updates;
  - then −1 per update to 0x40 after 191 more updates;
  - holds 0x40; `in_use[0]`=1 throughout.
- **Release:** same setup, release=0x00, gate low in SUSTAIN →
  - 0x40→0 in 64 updates;
  - `in_use[0]` falls on the edge where `env_out` reaches 0.
- **Retrigger:** gate high again during RELEASE at 0x20 → attack resumes from 0x20 upward, with no output below 0x20.
- **Sustain at full scale:** sustain=0xFF → reaches 0xFF and holds there; SUSTAIN is entered one update after the peak.
- **Independence and slow attack:** ch1 attack=0xFF (step 1) alongside other channels → `env_out[1]` reads 0x01 after exactly 256 updates. Other channels are unaffected.
- **`EG_EXP_RELEASE_EN` build:** release=0x00 from 0xFF00 gives the sequence 0xFF→0x7F→0x3F…, reaching IDLE.
